// File: rtl/tx_msg_framer.sv
// Frames one captured {addr, buysell, timestamp} order message into an 8-byte UART frame
// (SYNC, fields, XOR checksum) and paces bytes against the UART busy handshake.
module tx_msg_framer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         ACK_TIMEOUT = 4,
  parameter int         DROP_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            tx_addr,
  input  logic [7:0]            tx_buysell,
  input  logic [31:0]           tx_timestamp,
  input  logic                  tx_dv,
  output logic                  tx_busy,
  output logic [7:0]            uart_data,
  output logic                  uart_dv,
  input  logic                  uart_busy,
  output logic                  frame_done,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t      state, state_next;
  logic        tx_dv_q;
  logic        start;
  logic [7:0]  addr_r, buysell_r, csum_r;
  logic [31:0] ts_r;
  logic [2:0]  idx;
  logic [TW-1:0] timer;
  logic        load, strobe, timer_inc, advance, finish;
  logic [7:0]  cur_byte;

  assign start   = tx_dv & ~tx_dv_q;
  assign tx_busy = (state != IDLE);

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (idx)
      3'd0: cur_byte = SYNC_BYTE;
      3'd1: cur_byte = addr_r;
      3'd2: cur_byte = buysell_r;
      3'd3: cur_byte = ts_r[31:24];
      3'd4: cur_byte = ts_r[23:16];
      3'd5: cur_byte = ts_r[15:8];
      3'd6: cur_byte = ts_r[7:0];
      3'd7: cur_byte = csum_r;
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A UART that never acknowledges is tolerated: after the timeout the byte counts as sent.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    strobe     = 1'b0;
    timer_inc  = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (!uart_busy) begin
          strobe     = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (uart_busy || timer == TIMER_LAST) state_next = WAIT_DONE;
        else                                  timer_inc  = 1'b1;
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          if (idx == 3'd7) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_dv_q    <= 1'b0;
      uart_dv    <= 1'b0;
      uart_data  <= 8'd0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
      addr_r     <= 8'd0;
      buysell_r  <= 8'd0;
      ts_r       <= 32'd0;
      csum_r     <= 8'd0;
      idx        <= 3'd0;
      timer      <= '0;
    end else begin
      tx_dv_q    <= tx_dv;
      uart_dv    <= strobe;
      frame_done <= finish;
      if (load) begin
        addr_r    <= tx_addr;
        buysell_r <= tx_buysell;
        ts_r      <= tx_timestamp;
        csum_r    <= tx_addr ^ tx_buysell ^ tx_timestamp[31:24] ^ tx_timestamp[23:16]
                     ^ tx_timestamp[15:8] ^ tx_timestamp[7:0];
        idx       <= 3'd0;
      end
      if (strobe) begin
        uart_data <= cur_byte;
        timer     <= '0;
      end
      if (timer_inc) timer <= timer + TW'(1);
      if (advance)   idx   <= idx + 3'd1;
      // Messages arriving mid-frame are lost; the counter saturates so it never looks healthy again.
      if (start && state != IDLE && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tx_msg_framer.sv
// Directed bench for tx_msg_framer with a simple UART busy model and a byte monitor.
module tb_tx_msg_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  tx_addr = 8'd0;
  logic [7:0]  tx_buysell = 8'd0;
  logic [31:0] tx_timestamp = 32'd0;
  logic        tx_dv = 1'b0;
  logic        tx_busy;
  logic [7:0]  uart_data;
  logic        uart_dv;
  logic        uart_busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic       uart_never = 1'b0;
  logic       force_busy = 1'b0;
  logic [1:0] busy_cnt = 2'd0;

  logic [7:0] mon_bytes [0:1023];
  int         mon_cyc [0:1023];
  int         mon_count = 0;
  int         fd_count = 0;
  int         cycle = 0;

  tx_msg_framer dut (
    .clk(clk), .reset(reset), .tx_addr(tx_addr), .tx_buysell(tx_buysell),
    .tx_timestamp(tx_timestamp), .tx_dv(tx_dv), .tx_busy(tx_busy), .uart_data(uart_data),
    .uart_dv(uart_dv), .uart_busy(uart_busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // UART stand-in: busy for three cycles after each accepted strobe.
  always @(posedge clk) begin
    if (uart_dv && !uart_never) busy_cnt <= 2'd3;
    else if (busy_cnt != 2'd0)  busy_cnt <= busy_cnt - 2'd1;
  end
  assign uart_busy = force_busy | (busy_cnt != 2'd0);

  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (uart_dv && mon_count < 1024) begin
      mon_bytes[mon_count] <= uart_data;
      mon_cyc[mon_count]   <= cycle;
      mon_count            <= mon_count + 1;
    end
    if (frame_done) fd_count <= fd_count + 1;
  end

  task automatic send_msg(input logic [7:0] a, input logic [7:0] b, input logic [31:0] t,
                          input int hold);
    @(negedge clk);
    tx_addr = a; tx_buysell = b; tx_timestamp = t; tx_dv = 1'b1;
    repeat (hold) @(negedge clk);
    tx_dv = 1'b0;
  endtask

  task automatic wait_frame(output int busy_low, output bit timed_out);
    busy_low = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (frame_done) begin
        timed_out = 1'b0;
        break;
      end
      if (tx_busy !== 1'b1) busy_low++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({tx_busy, uart_dv, frame_done} !== 3'b000 || uart_data !== 8'h00 || drop_cnt !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: busy/dv/done=%b data=%02h drop=%0d, want 000 00 0",
               {tx_busy, uart_dv, frame_done}, uart_data, drop_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_frame;
    int base, fdb, busy_low; bit to; logic [63:0] expf; logic [7:0] eb;
    expf = 64'hA503011234567800 | 64'h0A;
    base = mon_count; fdb = fd_count;
    send_msg(8'h03, 8'h01, 32'h12345678, 1);
    wait_frame(busy_low, to);
    tests_run++;
    if (to || busy_low != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_frame_busy: timeout=%0d busy_low_cycles=%0d, want 0 0", to, busy_low);
    end
    tests_run++;
    if (mon_count - base != 8 || fd_count - fdb != 1) begin
      tests_failed++;
      $display("[TB] FAIL basic_frame_counts: bytes=%0d done=%0d, want 8 1", mon_count - base, fd_count - fdb);
    end
    for (int i = 0; i < 8; i++) begin
      eb = expf[63-8*i -: 8];
      tests_run++;
      if (mon_bytes[base+i] !== eb) begin
        tests_failed++;
        $display("[TB] FAIL basic_byte%0d: got %02h want %02h", i, mon_bytes[base+i], eb);
      end
    end
    tests_run++;
    if (drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL basic_drop: got %0d want 0", drop_cnt);
    end
  endtask

  task automatic test_held_dv;
    int base, fdb, busy_low; bit to; logic [63:0] expf; logic [7:0] eb;
    expf = 64'hA51002DEADBEEF30;
    base = mon_count; fdb = fd_count;
    send_msg(8'h10, 8'h02, 32'hDEADBEEF, 2);
    wait_frame(busy_low, to);
    repeat (60) @(negedge clk);
    tests_run++;
    if (to || mon_count - base != 8 || fd_count - fdb != 1 || drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL held_dv_one_frame: timeout=%0d bytes=%0d done=%0d drop=%0d, want 0 8 1 0",
               to, mon_count - base, fd_count - fdb, drop_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      eb = expf[63-8*i -: 8];
      tests_run++;
      if (mon_bytes[base+i] !== eb) begin
        tests_failed++;
        $display("[TB] FAIL held_byte%0d: got %02h want %02h", i, mon_bytes[base+i], eb);
      end
    end
  endtask

  task automatic test_drop_mid_frame;
    int base, fdb, busy_low, seen; bit to; logic [63:0] expf; logic [7:0] eb;
    expf = 64'hA503011234567800 | 64'h0A;
    base = mon_count; fdb = fd_count; seen = 0;
    send_msg(8'h03, 8'h01, 32'h12345678, 1);
    for (int c = 0; c < 200 && seen < 4; c++) begin
      @(negedge clk);
      if (uart_dv) seen++;
    end
    tx_addr = 8'h07; tx_buysell = 8'h02; tx_timestamp = 32'h0; tx_dv = 1'b1;
    @(negedge clk);
    tx_dv = 1'b0;
    wait_frame(busy_low, to);
    tests_run++;
    if (to || drop_cnt !== 8'd1 || fd_count - fdb != 1) begin
      tests_failed++;
      $display("[TB] FAIL drop_count: timeout=%0d drop=%0d done=%0d, want 0 1 1", to, drop_cnt, fd_count - fdb);
    end
    for (int i = 0; i < 8; i++) begin
      eb = expf[63-8*i -: 8];
      tests_run++;
      if (mon_bytes[base+i] !== eb) begin
        tests_failed++;
        $display("[TB] FAIL drop_frame_byte%0d: got %02h want %02h", i, mon_bytes[base+i], eb);
      end
    end
    expf = 64'hA507020000000005;
    base = mon_count;
    send_msg(8'h07, 8'h02, 32'h0, 1);
    wait_frame(busy_low, to);
    tests_run++;
    if (to || mon_count - base != 8 || drop_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL after_drop_frame: timeout=%0d bytes=%0d drop=%0d, want 0 8 1", to, mon_count - base, drop_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      eb = expf[63-8*i -: 8];
      tests_run++;
      if (mon_bytes[base+i] !== eb) begin
        tests_failed++;
        $display("[TB] FAIL after_drop_byte%0d: got %02h want %02h", i, mon_bytes[base+i], eb);
      end
    end
  endtask

  task automatic test_ack_timeout;
    int base, fdb, busy_low, gap; bit to; logic [63:0] expf; logic [7:0] eb;
    expf = 64'hA555AA01020304FB;
    uart_never = 1'b1;
    base = mon_count; fdb = fd_count;
    send_msg(8'h55, 8'hAA, 32'h01020304, 1);
    wait_frame(busy_low, to);
    tests_run++;
    if (to || mon_count - base != 8 || fd_count - fdb != 1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_frame: timeout=%0d bytes=%0d done=%0d, want 0 8 1", to, mon_count - base, fd_count - fdb);
    end
    for (int i = 0; i < 8; i++) begin
      eb = expf[63-8*i -: 8];
      tests_run++;
      if (mon_bytes[base+i] !== eb) begin
        tests_failed++;
        $display("[TB] FAIL timeout_byte%0d: got %02h want %02h", i, mon_bytes[base+i], eb);
      end
    end
    // SEND + four WAIT_ACK cycles + WAIT_DONE between strobes
    for (int i = 0; i < 7; i++) begin
      gap = mon_cyc[base+i+1] - mon_cyc[base+i];
      tests_run++;
      if (gap != 6) begin
        tests_failed++;
        $display("[TB] FAIL timeout_gap%0d: got %0d cycles want 6", i, gap);
      end
    end
    uart_never = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    int base, seen, snap, busy_low; bit to; logic [63:0] expf; logic [7:0] eb;
    seen = 0;
    send_msg(8'h44, 8'h01, 32'hCAFEF00D, 1);
    for (int c = 0; c < 200 && seen < 3; c++) begin
      @(negedge clk);
      if (uart_dv) seen++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (uart_dv !== 1'b0 || tx_busy !== 1'b0 || drop_cnt !== 8'd0 || uart_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_frame: dv=%b busy=%b drop=%0d data=%02h, want 0 0 0 00",
               uart_dv, tx_busy, drop_cnt, uart_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    snap = mon_count;
    repeat (40) @(negedge clk);
    tests_run++;
    if (mon_count != snap) begin
      tests_failed++;
      $display("[TB] FAIL reset_abandons: got %0d extra bytes want 0", mon_count - snap);
    end
    expf = 64'hA520030000000023;
    base = mon_count;
    send_msg(8'h20, 8'h03, 32'h0, 1);
    wait_frame(busy_low, to);
    tests_run++;
    if (to || mon_count - base != 8) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_frame: timeout=%0d bytes=%0d, want 0 8", to, mon_count - base);
    end
    for (int i = 0; i < 8; i++) begin
      eb = expf[63-8*i -: 8];
      tests_run++;
      if (mon_bytes[base+i] !== eb) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_byte%0d: got %02h want %02h", i, mon_bytes[base+i], eb);
      end
    end
  endtask

  task automatic test_drop_saturation;
    int snap;
    force_busy = 1'b1;
    snap = mon_count;
    send_msg(8'h11, 8'h22, 32'h33445566, 1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      tx_dv = 1'b1;
      @(negedge clk);
      tx_dv = 1'b0;
      if (i == 199) begin
        tests_run++;
        if (drop_cnt !== 8'd200) begin
          tests_failed++;
          $display("[TB] FAIL drop_count_200: got %0d want 200", drop_cnt);
        end
      end
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (drop_cnt !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL drop_saturate: got %0d want 255", drop_cnt);
    end
    tests_run++;
    if (mon_count != snap || tx_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL busy_hold: bytes=%0d busy=%b, want 0 1", mon_count - snap, tx_busy);
    end
    reset = 1'b1;
    force_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_held_dv();
    test_drop_mid_frame();
    test_ack_timeout();
    test_reset_mid_frame();
    test_drop_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
